// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bundle: instruction-memory request/ack channel plus the
// held-instruction / retire channel towards decode and control.
`timescale 1ns/1ps
interface instruction_fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction memory side
  logic [ADDR_WIDTH-1:0] o_imemAddr;
  logic                  o_imemReq;
  logic                  i_imemAck;
  logic [DATA_WIDTH-1:0] i_imemData;
  // decode / controller side
  logic [DATA_WIDTH-1:0] o_inst;
  logic [ADDR_WIDTH-1:0] o_pc;
  logic                  o_instValid;
  logic                  i_instAccept;
  logic [1:0]            i_pcNextSel;
  logic [ADDR_WIDTH-1:0] i_offset;
  logic [ADDR_WIDTH-1:0] i_regRS1;
  logic                  o_trap;
  logic [31:0]           o_instret;

  // fetch unit drives the o_* signals
  modport master (
    output o_imemAddr, o_imemReq, o_inst, o_pc, o_instValid, o_trap, o_instret,
    input  i_imemAck, i_imemData, i_instAccept, i_pcNextSel, i_offset, i_regRS1
  );

  // memory model / downstream stage drive the i_* signals
  modport slave (
    input  o_imemAddr, o_imemReq, o_inst, o_pc, o_instValid, o_trap, o_instret,
    output i_imemAck, i_imemData, i_instAccept, i_pcNextSel, i_offset, i_regRS1
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches one word at a time over a req/ack
// handshake, holds it for decode until it retires, then computes the next PC
// from the controller's select. Misaligned targets raise a sticky trap that
// only reset clears. Also counts retired instructions.
`timescale 1ns/1ps
module instruction_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic               i_clock,
  input  logic               i_reset,
  instruction_fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [DATA_WIDTH-1:0] inst;
  logic                  req;
  logic                  inst_valid;
  logic                  trap;
  logic [31:0]           instret_cnt;

  logic [ADDR_WIDTH-1:0] target;
  logic                  target_bad;

  // Next-PC selection. The offset arrives already sign-extended, so a plain
  // modulo-2^ADDR_WIDTH add covers backward branches. Indirect jumps drop
  // bit 0 of the sum before the alignment check.
  function automatic logic [ADDR_WIDTH-1:0] next_pc(
    input logic [1:0]            sel,
    input logic [ADDR_WIDTH-1:0] cur_pc,
    input logic [ADDR_WIDTH-1:0] off,
    input logic [ADDR_WIDTH-1:0] rs1
  );
    logic [ADDR_WIDTH-1:0] sum;
    case (sel)
      2'b01:   sum = cur_pc + off;
      2'b10: begin
        sum    = rs1 + off;
        sum[0] = 1'b0;
      end
      default: sum = cur_pc + ADDR_WIDTH'(4);
    endcase
    return sum;
  endfunction

  // Instruction words are 4-byte aligned; any low bit set is a fault.
  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |addr[1:0];
  endfunction

  // Target of the currently held instruction, evaluated from the retire inputs.
  always_comb begin
    target     = next_pc(bus.i_pcNextSel, inst_pc, bus.i_offset, bus.i_regRS1);
    target_bad = is_misaligned(target);
  end

  // Fetch/hold/trap sequencer with all outputs registered. The request is
  // held low for the first cycle out of reset so an ack coinciding with
  // reset release can never be mistaken for a completed fetch.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_FETCH;
      pc          <= RESET_VECTOR;
      inst_pc     <= RESET_VECTOR;
      inst        <= '0;
      req         <= 1'b0;
      inst_valid  <= 1'b0;
      trap        <= 1'b0;
      instret_cnt <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!req) begin
            req <= 1'b1;
          end else if (bus.i_imemAck) begin
            inst       <= bus.i_imemData;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            req        <= 1'b0;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.i_instAccept) begin
            instret_cnt <= instret_cnt + 32'd1;
            inst_valid  <= 1'b0;
            if (target_bad) begin
              // pc is left at the faulting instruction's address
              trap  <= 1'b1;
              state <= ST_TRAP;
            end else begin
              // next request goes out the cycle after retire
              pc    <= target;
              req   <= 1'b1;
              state <= ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          req        <= 1'b0;
          inst_valid <= 1'b0;
        end
        default: begin
          req        <= 1'b0;
          inst_valid <= 1'b0;
          state      <= ST_FETCH;
        end
      endcase
    end
  end

  assign bus.o_imemAddr  = pc;
  assign bus.o_imemReq   = req;
  assign bus.o_inst      = inst;
  assign bus.o_pc        = inst_pc;
  assign bus.o_instValid = inst_valid;
  assign bus.o_trap      = trap;
  assign bus.o_instret   = instret_cnt;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: memory responder with configurable wait
// states, downstream retire driver with a reference next-PC model, and a
// scoreboard monitor comparing each delivered instruction or trap.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int          AW = 32;
  localparam int          DW = 32;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  instruction_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VECTOR(RV)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (ifc.master)
  );

  typedef struct {
    logic        is_trap;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] instret;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  bit          m_trapped;

  // memory responder controls
  int wait_fixed = 0;   // >=0: fixed wait states, <0: random up to wait_max
  int wait_max   = 0;
  bit spurious   = 1'b0;

  // Memory contents: an address-derived word, 0x13 at address 0.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: acks after the chosen number of wait states; random junk acks
  // while no request is outstanding when spurious is enabled.
  initial begin
    int  cnt;
    bit  need_load;
    cnt       = 0;
    need_load = 1'b1;
    ifc.i_imemAck  = 1'b0;
    ifc.i_imemData = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        need_load = 1'b1;
        ifc.i_imemAck  = 1'b0;
        ifc.i_imemData = $urandom;
      end else if (ifc.o_imemReq) begin
        if (need_load) begin
          cnt = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, wait_max));
          need_load = 1'b0;
        end
        if (cnt == 0) begin
          ifc.i_imemAck  = 1'b1;
          ifc.i_imemData = mem_word(ifc.o_imemAddr);
          need_load      = 1'b1;
        end else begin
          ifc.i_imemAck  = 1'b0;
          ifc.i_imemData = $urandom;
          cnt--;
        end
      end else begin
        ifc.i_imemAck  = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
        ifc.i_imemData = $urandom;
      end
    end
  end

  // Monitor: samples just after each rising edge, pops the scoreboard when an
  // instruction is delivered or the trap rises, and checks handshake rules.
  initial begin
    logic        pv, pr, pt;
    logic [31:0] pa, pinst, ppc, pret;
    logic        rose;
    int          idle;
    exp_t        e;
    pv = 0; pr = 0; pt = 0; pa = 0; pinst = 0; ppc = 0; pret = 0; idle = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pv = 0; pr = 0; pt = 0; idle = 0;
        continue;
      end
      rose = pr && ifc.i_imemAck;
      check("valid_timing", ifc.o_instValid, rose || (pv && !ifc.i_instAccept));
      if (pr && !ifc.i_imemAck) begin
        check("req_stable", ifc.o_imemReq, 1'b1);
        check("addr_stable", ifc.o_imemAddr, pa);
      end
      if (pv && ifc.o_instValid) begin
        check("hold_inst_stable", ifc.o_inst, pinst);
        check("hold_pc_stable", ifc.o_pc, ppc);
      end
      if (ifc.o_instValid && !pv) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_fetch actual=pc %h required=no pending fetch", ifc.o_pc);
        end else begin
          e = exp_q.pop_front();
          check("fetch_kind", ifc.o_trap, e.is_trap);
          check("fetch_pc", ifc.o_pc, e.pc);
          check("fetch_inst", ifc.o_inst, e.inst);
          check("fetch_instret", ifc.o_instret, e.instret);
        end
        idle = 0;
      end
      if (ifc.o_trap && !pt) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_trap actual=pc %h required=no pending trap", ifc.o_pc);
        end else begin
          e = exp_q.pop_front();
          check("trap_kind", 1'b1, e.is_trap);
          check("trap_pc", ifc.o_pc, e.pc);
          check("trap_instret", ifc.o_instret, e.instret);
        end
        idle = 0;
      end
      if (pt) begin
        check("trap_sticky", ifc.o_trap, 1'b1);
        check("trap_pc_frozen", ifc.o_pc, ppc);
        check("trap_instret_frozen", ifc.o_instret, pret);
      end
      if (ifc.o_trap) begin
        check("trap_req_low", ifc.o_imemReq, 1'b0);
        check("trap_valid_low", ifc.o_instValid, 1'b0);
      end
      if (exp_q.size() > 0) idle++;
      if (idle > 100) begin
        checks++; failures++;
        $display("FAIL scoreboard_timeout actual=%0d pending required=0", exp_q.size());
        exp_q.delete();
        idle = 0;
      end
      pv = ifc.o_instValid; pr = ifc.o_imemReq; pt = ifc.o_trap;
      pa = ifc.o_imemAddr; pinst = ifc.o_inst; ppc = ifc.o_pc; pret = ifc.o_instret;
    end
  end

  // Release reset at a falling edge with a fresh model and the first expected fetch.
  task automatic release_reset();
    exp_q.delete();
    m_pc      = RV;
    m_instret = 32'd0;
    m_trapped = 1'b0;
    exp_q.push_back('{1'b0, RV, mem_word(RV), 32'd0});
    rst_n = 1'b1;
  endtask

  // Assert reset between clock edges and check that outputs clear at once.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_req", ifc.o_imemReq, 1'b0);
    check("rst_valid", ifc.o_instValid, 1'b0);
    check("rst_trap", ifc.o_trap, 1'b0);
    check("rst_instret", ifc.o_instret, 32'd0);
    check("rst_inst", ifc.o_inst, 32'd0);
    check("rst_addr", ifc.o_imemAddr, RV);
    ifc.i_instAccept = 1'b0;
    @(negedge clk);
    @(negedge clk);
    release_reset();
  endtask

  // Wait (bounded) at falling edges until an instruction is held.
  task automatic wait_valid();
    int g;
    g = 0;
    while (!ifc.o_instValid && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!ifc.o_instValid) begin
      checks++; failures++;
      $display("FAIL wait_valid_timeout actual=0 required=1");
    end
  endtask

  // Retire the next instruction with the given select inputs. Junk accepts
  // are driven while nothing is held; the model predicts the outcome.
  task automatic accept_one(input logic [1:0] sel, input logic [31:0] off,
                            input logic [31:0] rs1, input int hold);
    int          g;
    logic [31:0] t;
    g = 0;
    while (!ifc.o_instValid && g < 200) begin
      ifc.i_instAccept = 1'($urandom_range(0, 1));
      ifc.i_pcNextSel  = 2'($urandom);
      ifc.i_offset     = $urandom;
      ifc.i_regRS1     = $urandom;
      @(negedge clk);
      g++;
    end
    ifc.i_instAccept = 1'b0;
    if (!ifc.o_instValid) begin
      checks++; failures++;
      $display("FAIL accept_timeout actual=0 required=1");
      return;
    end
    repeat (hold) @(negedge clk);
    ifc.i_instAccept = 1'b1;
    ifc.i_pcNextSel  = sel;
    ifc.i_offset     = off;
    ifc.i_regRS1     = rs1;
    case (sel)
      2'b01: t = m_pc + off;
      2'b10: t = (rs1 + off) & 32'hFFFF_FFFE;
      default: t = m_pc + 32'd4;
    endcase
    m_instret = m_instret + 32'd1;
    if (t[1:0] != 2'b00) begin
      exp_q.push_back('{1'b1, m_pc, 32'd0, m_instret});
      m_trapped = 1'b1;
    end else begin
      m_pc = t;
      exp_q.push_back('{1'b0, t, mem_word(t), m_instret});
    end
    @(negedge clk);
    ifc.i_instAccept = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, g;
    logic [1:0]  sel;
    logic [31:0] off, rs1;
    ifc.i_instAccept = 1'b0;
    ifc.i_pcNextSel  = 2'b00;
    ifc.i_offset     = '0;
    ifc.i_regRS1     = '0;

    // power-on reset, zero-wait memory
    repeat (3) @(negedge clk);
    check("por_req", ifc.o_imemReq, 1'b0);
    check("por_valid", ifc.o_instValid, 1'b0);
    check("por_instret", ifc.o_instret, 32'd0);
    release_reset();
    @(negedge clk);
    check("first_req", ifc.o_imemReq, 1'b1);
    check("first_addr", ifc.o_imemAddr, 32'h0);
    check("first_valid_early", ifc.o_instValid, 1'b0);
    @(negedge clk);
    check("first_valid", ifc.o_instValid, 1'b1);
    check("first_inst", ifc.o_inst, 32'h0000_0013);
    check("first_pc", ifc.o_pc, 32'h0);
    for (int i = 0; i < 3; i++) accept_one(2'b00, $urandom, $urandom, 0);
    wait_valid();
    check("seq_pc", ifc.o_pc, 32'h0000_000C);
    check("seq_instret", ifc.o_instret, 32'd3);

    // three wait states, then a long hold with junk acks
    wait_fixed = 3;
    accept_one(2'b00, 32'd0, 32'd0, 1);
    n = 0; g = 0;
    while (!ifc.o_instValid && g < 50) begin
      if (ifc.o_imemReq) n++;
      @(negedge clk);
      g++;
    end
    check("wait_req_cycles", n, 4);
    spurious = 1'b1;
    repeat (5) @(negedge clk);
    check("hold_inst", ifc.o_inst, mem_word(32'h10));
    check("hold_pc", ifc.o_pc, 32'h10);
    wait_fixed = 0;

    // relative branches and misaligned branch trap
    accept_one(2'b01, 32'h0000_00F0, 32'd0, 0);
    wait_valid();
    check("br_pc_100", ifc.o_pc, 32'h100);
    accept_one(2'b01, 32'hFFFF_FFF8, 32'd0, 0);
    wait_valid();
    check("br_back_pc", ifc.o_pc, 32'hF8);
    accept_one(2'b01, 32'h0000_0008, 32'd0, 0);
    accept_one(2'b01, 32'h0000_0006, 32'd0, 0);
    repeat (3) begin
      ifc.i_instAccept = 1'b1;
      @(negedge clk);
    end
    ifc.i_instAccept = 1'b0;
    check("br_trap", ifc.o_trap, 1'b1);
    check("br_trap_req", ifc.o_imemReq, 1'b0);
    check("br_trap_pc", ifc.o_pc, 32'h100);
    check("br_trap_instret", ifc.o_instret, 32'd8);

    // indirect jumps
    do_reset();
    accept_one(2'b10, 32'h0000_0003, 32'h0000_2001, 0);
    wait_valid();
    check("jalr_pc", ifc.o_pc, 32'h2004);
    check("jalr_inst", ifc.o_inst, mem_word(32'h2004));
    accept_one(2'b10, 32'h0000_0001, 32'h0000_2001, 0);
    repeat (2) @(negedge clk);
    check("jalr_trap", ifc.o_trap, 1'b1);
    check("jalr_trap_pc", ifc.o_pc, 32'h2004);

    // reset with a request pending, then reset while holding
    do_reset();
    wait_fixed = 8;
    @(negedge clk);
    check("pend_req", ifc.o_imemReq, 1'b1);
    do_reset();
    wait_fixed = 0;
    @(negedge clk);
    check("rerel_req", ifc.o_imemReq, 1'b1);
    check("rerel_addr", ifc.o_imemAddr, RV);
    wait_valid();
    accept_one(2'b00, 32'd0, 32'd0, 0);
    wait_valid();
    do_reset();

    // instret wrap and select 11
    wait_valid();
    force dut.instret_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instret_cnt;
    m_instret = 32'hFFFF_FFFF;
    @(negedge clk);
    check("preload_instret", ifc.o_instret, 32'hFFFF_FFFF);
    accept_one(2'b11, $urandom, $urandom, 0);
    wait_valid();
    check("wrap_instret", ifc.o_instret, 32'd0);
    check("sel11_pc", ifc.o_pc, 32'h4);

    // randomized retire stream with random wait states
    wait_fixed = -1;
    wait_max   = 3;
    for (int i = 0; i < 250; i++) begin
      if (m_trapped) do_reset();
      sel = 2'($urandom);
      off = ($urandom_range(0, 15) == 0) ? $urandom
            : (($urandom & 32'h0000_0FFC) - 32'h0000_0800);
      rs1 = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      accept_one(sel, off, rs1, int'($urandom_range(0, 2)));
    end

    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream stage of the datapath controller: owns the PC, fetches instruction words from instruction memory over a req/ack handshake, and presents the held instruction to decode/control.
- Consumes the controller's 2-bit next-PC select plus the branch offset and RS1 value to compute the next PC when the current instruction retires.
- Also maintains a retired-instruction counter and a sticky misaligned-target trap.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction memory address.
- DATA_WIDTH, 32, instruction word width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- o_imemAddr  out  ADDR_WIDTH  instruction memory byte address.
- o_imemReq  out  1  fetch request.
- i_imemAck  in  1  memory has placed the word on i_imemData this cycle.
- i_imemData  in  DATA_WIDTH  instruction word, valid when i_imemAck=1.
- o_inst  out  DATA_WIDTH  held instruction to decode/controller.
- o_pc  out  ADDR_WIDTH  PC of o_inst.
- o_instValid  out  1  o_inst/o_pc valid.
- i_instAccept  in  1  downstream retires o_inst this cycle; the select/offset/RS1 inputs are sampled now.
- i_pcNextSel  in  2  00 PC+4, 01 PC+offset, 10 RS1+offset, 11 treated as PC+4.
- i_offset  in  ADDR_WIDTH  sign-extended immediate.
- i_regRS1  in  ADDR_WIDTH  RS1 value for indirect jumps.
- o_trap  out  1  sticky misaligned-target trap.
- o_instret  out  32  retired-instruction count.

Behaviour:
- Reset (async assert, any state) forces:
  - state=FETCH, PC=RESET_VECTOR, o_inst=0, o_instValid=0, o_trap=0, o_instret=0.
  - o_imemReq=0 while i_reset is low.
  - Any outstanding request is abandoned; a late ack after reset release is taken as the ack of the new fetch.
- FSM states:
  - FETCH: o_imemReq=1, o_imemAddr=PC, both held stable until the ack. On i_imemAck: o_inst<=i_imemData, o_pc<=PC, o_instValid<=1, go to HOLD. A same-cycle ack gives o_instValid one cycle after the request is first asserted.
  - HOLD: o_imemReq=0, o_inst/o_pc held stable. i_imemAck is ignored. On i_instAccept:
    - compute target; o_instret<=o_instret+1 (wraps 2^32-1 -> 0); o_instValid<=0.
    - if target[1:0]!=0: o_trap<=1, go to TRAP.
    - else PC<=target, go to FETCH.
  - TRAP: o_imemReq=0, o_instValid=0, PC frozen at the faulting instruction's PC, i_instAccept ignored. Only reset exits.
- Target arithmetic (ADDR_WIDTH, wraps modulo 2^ADDR_WIDTH, no overflow flag):
  - 00/11: o_pc+4.
  - 01: o_pc+i_offset.
  - 10: (i_regRS1+i_offset) with bit 0 cleared, then alignment-checked on bit 1.
  - 01: checked on bits [1:0].
- Retire-to-request latency: request with the new address is asserted the cycle after i_instAccept, giving a minimum of 2 cycles per instruction with zero-wait memory.
- i_instAccept while o_instValid=0 has no effect.
- i_imemAck in the same cycle as reset deassertion is ignored.

Test Plan:
- Reset release with RESET_VECTOR=0, memory acks same cycle returning 0x00000013 -> cycle 1: o_imemReq=1, addr 0x0; cycle 2: o_instValid=1, o_inst=0x00000013, o_pc=0; three accepts with sel=00 -> addresses 0x4, 0x8, 0xC; o_instret=3.
- Memory inserts 3 wait states -> o_imemReq and o_imemAddr stable for 4 cycles; o_instValid rises exactly one cycle after the ack; o_inst unchanged while HOLD waits 5 cycles without accept.
- At o_pc=0x100, accept with sel=01 and i_offset=0xFFFFFFF8 -> next fetch address 0xF8; with sel=01 and i_offset=0x6 -> o_trap=1, o_imemReq stays 0, o_pc=0x100, o_instret incremented.
- JALR case: sel=10, i_regRS1=0x2001, i_offset=0x3 -> target 0x2004 fetched; i_regRS1=0x2001, i_offset=0x1 -> 0x2002 -> trap.
- Reset asserted mid-FETCH (request pending, no ack) and mid-HOLD -> outputs reset immediately without a clock; first request after release goes to RESET_VECTOR.
- Preload o_instret=0xFFFFFFFF via 2^32-1 accepts (forced in the bench) -> next accept gives 0; sel=11 behaves as PC+4.
